// File: rtl/alu_sched_pkg.sv
// Shared types and ALU opcode encodes for the sequential-path scheduler.
// The opcode values must match the ones decoded by the alu instance.
package alu_sched_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } sched_state_t;

    localparam logic [3:0] ALU_OP_SLL = 4'd5;
    localparam logic [3:0] ALU_OP_SRL = 4'd6;
    localparam logic [3:0] ALU_OP_MUL = 4'd7;

endpackage

// File: rtl/alu_seq_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        logic [IDX_W-1:0] slot;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        slot  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[slot]) begin
                any         = 1'b1;
                grant[slot] = 1'b1;
                idx         = slot;
            end
        end
    end

endmodule

// File: rtl/alu_seq_scheduler.sv
// Shares the ALU multi-cycle path (SRL/SLL/MUL) between issue slots: round-robin
// grant, one-cycle start pulse, completion/watchdog tracking and a tagged response.
//
// state     | meaning
// IDLE      | waiting for a request; grant and latch operands on handshake
// ISSUE     | alu_enable_seq pulse, watchdog cleared
// LAUNCH    | gives the ALU one cycle to leave its idle state
// WAIT_DONE | waiting for alu_idle or watchdog expiry
// RESP      | one-cycle tagged response to the granted slot
module alu_seq_scheduler
    import alu_sched_pkg::*;
#(
    parameter  int OPERAND_WIDTH    = 64,
    parameter  int OPCODE_ALU_WIDTH = 4,
    parameter  int NUM_REQ          = 2,
    parameter  int TIMEOUT_CYCLES   = 128,
    localparam int IDX_W            = $clog2(NUM_REQ),
    localparam int WD_W             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0]     req_operand_1,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0]     req_operand_2,
    input  logic [NUM_REQ*OPCODE_ALU_WIDTH-1:0]  req_op_code,
    output logic [OPERAND_WIDTH-1:0]             alu_operand_1,
    output logic [OPERAND_WIDTH-1:0]             alu_operand_2,
    output logic [OPCODE_ALU_WIDTH-1:0]          alu_op_code,
    output logic                                 alu_enable_seq,
    input  logic                                 alu_idle,
    input  logic [OPERAND_WIDTH-1:0]             alu_result,
    output logic                                 rsp_valid,
    output logic [IDX_W-1:0]                     rsp_id,
    output logic [OPERAND_WIDTH-1:0]             rsp_result,
    output logic                                 rsp_timeout,
    output logic                                 busy
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    sched_state_t state, state_nxt;

    logic [NUM_REQ-1:0]          arb_grant;
    logic [IDX_W-1:0]            arb_idx;
    logic                        arb_any;
    logic [IDX_W-1:0]            rr_ptr;
    logic [IDX_W-1:0]            gnt_idx;
    logic [OPERAND_WIDTH-1:0]    op1_q, op2_q, res_q;
    logic [OPCODE_ALU_WIDTH-1:0] opc_q;
    logic                        timeout_q;
    logic [WD_W-1:0]             watchdog;
    logic                        wd_expired;

    logic [OPERAND_WIDTH-1:0]    slot_op1 [NUM_REQ];
    logic [OPERAND_WIDTH-1:0]    slot_op2 [NUM_REQ];
    logic [OPCODE_ALU_WIDTH-1:0] slot_opc [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign slot_op1[i] = req_operand_1[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        assign slot_op2[i] = req_operand_2[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        assign slot_opc[i] = req_op_code[i*OPCODE_ALU_WIDTH +: OPCODE_ALU_WIDTH];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign wd_expired = (watchdog == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        req_ready      = '0;
        alu_enable_seq = 1'b0;
        rsp_valid      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = arb_grant;
                if (arb_any) state_nxt = ISSUE;
            end
            ISSUE: begin
                alu_enable_seq = 1'b1;
                state_nxt      = LAUNCH;
            end
            LAUNCH:    state_nxt = WAIT_DONE;
            WAIT_DONE: if (alu_idle || wd_expired) state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // Watchdog counts from LAUNCH, so an abort answers TIMEOUT_CYCLES cycles after LAUNCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            opc_q     <= '0;
            res_q     <= '0;
            timeout_q <= 1'b0;
            watchdog  <= '0;
        end else begin
            case (state)
                IDLE: if (arb_any) begin
                    op1_q   <= slot_op1[arb_idx];
                    op2_q   <= slot_op2[arb_idx];
                    opc_q   <= slot_opc[arb_idx];
                    gnt_idx <= arb_idx;
                    rr_ptr  <= (arb_idx == IDX_LAST) ? '0 : arb_idx + IDX_W'(1);
                end
                ISSUE: begin
                    watchdog  <= '0;
                    res_q     <= '0;
                    timeout_q <= 1'b0;
                end
                LAUNCH: if (watchdog != WD_MAX) watchdog <= watchdog + WD_W'(1);
                WAIT_DONE: begin
                    if (watchdog != WD_MAX) watchdog <= watchdog + WD_W'(1);
                    if (alu_idle) begin
                        res_q     <= alu_result;
                        timeout_q <= 1'b0;
                    end else if (wd_expired) begin
                        res_q     <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign alu_operand_1 = busy ? op1_q : '0;
    assign alu_operand_2 = busy ? op2_q : '0;
    assign alu_op_code   = busy ? opc_q : '0;
    assign rsp_id        = rsp_valid ? gnt_idx : '0;
    assign rsp_result    = rsp_valid ? res_q : '0;
    assign rsp_timeout   = rsp_valid & timeout_q;

endmodule
